// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the digit-serial N x N multiplier.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StCalc = 3'd1,
    StFix  = 3'd2,
    StDone = 3'd3
  } state_e;

  function automatic int unsigned num_digits(int unsigned data_w, int unsigned digit_w);
    return (digit_w == 0) ? 1 : data_w / digit_w;
  endfunction

  function automatic int unsigned num_pp(int unsigned data_w, int unsigned digit_w);
    return num_digits(data_w, digit_w) * num_digits(data_w, digit_w);
  endfunction

  function automatic bit params_legal(int unsigned data_w, int unsigned digit_w);
    return (digit_w >= 1) && (data_w % digit_w == 0);
  endfunction

endpackage

// File: rtl/seq_mult_nxn_if.sv
// Request/response bundle between the operand registers and the multiplier.
interface seq_mult_nxn_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic                  start;
  logic                  abort;
  logic                  signed_mode;
  logic [DATA_W-1:0]     dataa;
  logic [DATA_W-1:0]     datab;
  logic                  busy;
  logic                  done_flag;
  logic [2*DATA_W-1:0]   product8x8_out;
  logic [2:0]            state_out;

  modport master (
    output start, abort, signed_mode, dataa, datab,
    input  busy, done_flag, product8x8_out, state_out
  );

  modport slave (
    input  start, abort, signed_mode, dataa, datab,
    output busy, done_flag, product8x8_out, state_out
  );

endinterface

// File: rtl/digit_mult.sv
// Combinational unsigned DIGIT_W x DIGIT_W multiplier.
module digit_mult #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0]   a,
  input  logic [DIGIT_W-1:0]   b,
  output logic [2*DIGIT_W-1:0] p
);

  always_comb p = {{DIGIT_W{1'b0}}, a} * {{DIGIT_W{1'b0}}, b};

endmodule

// File: rtl/seq_mult_nxn.sv
// Sequential signed/unsigned multiplier accumulating one digit partial product per clock.
module seq_mult_nxn
  import seq_mult_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic         clk,
  input  logic         reset_a,
  seq_mult_nxn_if.slave bus
);

  localparam int unsigned ND     = num_digits(DATA_W, DIGIT_W);
  localparam int unsigned NPP    = num_pp(DATA_W, DIGIT_W);
  localparam int unsigned PW     = (NPP > 1) ? $clog2(NPP) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  if (!params_legal(DATA_W, DIGIT_W)) begin : g_bad_params
    $error("seq_mult_nxn: DATA_W must be a non-zero multiple of DIGIT_W");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic                neg_q, neg_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PW-1:0]       pp_idx_q, pp_idx_d;

  logic                accept, pp_last;
  logic [DATA_W-1:0]   a_mag, b_mag;
  int unsigned         dig_i, dig_j;
  logic [DIGIT_W-1:0]  dig_a, dig_b;
  logic [2*DIGIT_W-1:0] pp;
  logic [PROD_W-1:0]   pp_shift;

  assign accept  = (state_q == StIdle) && bus.start && !bus.abort;
  assign pp_last = (pp_idx_q == PW'(NPP - 1));

  // Magnitudes; the most negative value maps onto 2^(DATA_W-1), still representable unsigned.
  always_comb begin
    a_mag = bus.dataa;
    b_mag = bus.datab;
    if (bus.signed_mode && bus.dataa[DATA_W-1]) a_mag = -bus.dataa;
    if (bus.signed_mode && bus.datab[DATA_W-1]) b_mag = -bus.datab;
  end

  always_comb begin
    dig_i    = 32'(pp_idx_q) % ND;
    dig_j    = 32'(pp_idx_q) / ND;
    dig_a    = DIGIT_W'(ma_q >> (dig_i * DIGIT_W));
    dig_b    = DIGIT_W'(mb_q >> (dig_j * DIGIT_W));
    pp_shift = PROD_W'(pp) << ((dig_i + dig_j) * DIGIT_W);
  end

  digit_mult #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_mult (
    .a (dig_a),
    .b (dig_b),
    .p (pp)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q  <= StIdle;
      ma_q     <= '0;
      mb_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
      pp_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      pp_idx_q <= pp_idx_d;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (pp_last) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.abort) state_d = StIdle;
  end

  always_comb begin
    ma_d     = ma_q;
    mb_d     = mb_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    pp_idx_d = pp_idx_q;
    if (accept) begin
      ma_d     = a_mag;
      mb_d     = b_mag;
      neg_d    = bus.signed_mode & (bus.dataa[DATA_W-1] ^ bus.datab[DATA_W-1]);
      acc_d    = '0;
      pp_idx_d = '0;
    end else if (bus.abort) begin
      pp_idx_d = '0;
    end else if (state_q == StCalc) begin
      acc_d    = acc_q + pp_shift;
      pp_idx_d = pp_last ? '0 : pp_idx_q + PW'(1);
    end else if (state_q == StFix) begin
      prod_d = neg_q ? -acc_q : acc_q;
    end
  end

  // Outputs decode straight from registers.
  always_comb begin
    bus.busy           = 1'b0;
    bus.done_flag      = 1'b0;
    bus.state_out      = StIdle;
    bus.product8x8_out = prod_q;
    unique case (state_q)
      StIdle: ;
      StCalc: begin
        bus.busy      = 1'b1;
        bus.state_out = StCalc;
      end
      StFix: begin
        bus.busy      = 1'b1;
        bus.state_out = StFix;
      end
      StDone: begin
        bus.done_flag = 1'b1;
        bus.state_out = StDone;
      end
      default: ;
    endcase
  end

endmodule
